// File: rtl/fofir_tap_sel_ctrl.sv
// Tap-select sequencer for the FoFIR PE 5-input operand mux: walks the active taps once per pass.
// Define FOFIR_TAP_MASK_EN to honour tap_mask; otherwise every tap below num_taps is active.
module fofir_tap_sel_ctrl #(
    parameter int NUM_IN = 5,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        num_taps,
    input  logic [4:0]        tap_mask,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              stall,
    output logic [2:0]        sel,
    output logic              sel_valid,
    output logic              first_tap,
    output logic              last_tap,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [4:0]        act, act_nxt;
    logic [PASS_W-1:0] passes, passes_nxt;
    logic [PASS_W-1:0] pass_cnt, pass_nxt;
    logic [2:0]        sel_nxt;
    logic              valid_nxt, first_nxt, last_nxt, busy_nxt, done_nxt, err_nxt;
    logic [4:0]        start_act;
    logic              start_legal;

    function automatic logic [4:0] taps_below(input logic [2:0] n);
        logic [4:0] a;
        a = '0;
        for (int i = 0; i < 5; i++) a[i] = (i < NUM_IN) && (3'(i) < n);
        return a;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [4:0] a);
        logic [2:0] r;
        r = '0;
        for (int i = 4; i >= 0; i--) if (a[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] highest_idx(input logic [4:0] a);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) if (a[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] next_idx(input logic [4:0] a, input logic [2:0] s);
        logic [2:0] r;
        r = '0;
        for (int i = 4; i >= 0; i--) if (a[i] && (3'(i) > s)) r = 3'(i);
        return r;
    endfunction

`ifdef FOFIR_TAP_MASK_EN
    assign start_act = taps_below(num_taps) & tap_mask;
`else
    logic unused_tap_mask;
    assign unused_tap_mask = ^tap_mask;
    assign start_act = taps_below(num_taps);
`endif

    assign start_legal = (num_taps != 3'd0) && (32'(num_taps) <= NUM_IN) &&
                         (num_passes != '0) && (start_act != 5'd0);

    always_comb begin
        state_nxt  = state;
        act_nxt    = act;
        passes_nxt = passes;
        pass_nxt   = pass_cnt;
        sel_nxt    = sel;
        valid_nxt  = sel_valid;
        first_nxt  = first_tap;
        last_nxt   = last_tap;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt   = '0;
                valid_nxt = 1'b0;
                first_nxt = 1'b0;
                last_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                if (start) begin
                    if (start_legal) begin
                        state_nxt  = RUN;
                        act_nxt    = start_act;
                        passes_nxt = num_passes;
                        pass_nxt   = '0;
                        sel_nxt    = lowest_idx(start_act);
                        valid_nxt  = 1'b1;
                        first_nxt  = 1'b1;
                        last_nxt   = lowest_idx(start_act) == highest_idx(start_act);
                        busy_nxt   = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                // A stalled cycle keeps every registered output and the pass count.
                if (!stall) begin
                    if (sel != highest_idx(act)) begin
                        sel_nxt   = next_idx(act, sel);
                        first_nxt = 1'b0;
                        last_nxt  = next_idx(act, sel) == highest_idx(act);
                    end else if (({1'b0, pass_cnt} + (PASS_W+1)'(1)) < {1'b0, passes}) begin
                        pass_nxt  = pass_cnt + 1'b1;
                        sel_nxt   = lowest_idx(act);
                        first_nxt = 1'b1;
                        last_nxt  = lowest_idx(act) == highest_idx(act);
                    end else begin
                        state_nxt = DONE;
                        sel_nxt   = '0;
                        valid_nxt = 1'b0;
                        first_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
                valid_nxt = 1'b0;
                first_nxt = 1'b0;
                last_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
                valid_nxt = 1'b0;
                first_nxt = 1'b0;
                last_nxt  = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            act       <= '0;
            passes    <= '0;
            pass_cnt  <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            first_tap <= 1'b0;
            last_tap  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            act       <= act_nxt;
            passes    <= passes_nxt;
            pass_cnt  <= pass_nxt;
            sel       <= sel_nxt;
            sel_valid <= valid_nxt;
            first_tap <= first_nxt;
            last_tap  <= last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cfg_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fofir_tap_sel_ctrl.sv
// Self-checking bench for fofir_tap_sel_ctrl: directed scenarios plus randomized configs/stalls
// compared against a tap-list reference model (mask honoured when FOFIR_TAP_MASK_EN is defined).
module tb_fofir_tap_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] num_taps;
    logic [4:0] tap_mask;
    logic [7:0] num_passes;
    logic       stall;
    logic [2:0] sel;
    logic       sel_valid, first_tap, last_tap, busy, done, cfg_err;

    int checks = 0;
    int passed = 0;

    int cfg_nt;
    logic [4:0] cfg_mask;
    int cfg_np;

    int exp_sel[$];
    bit exp_first[$];
    bit exp_last[$];

    fofir_tap_sel_ctrl #(.NUM_IN(5), .PASS_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_taps(num_taps),
        .tap_mask(tap_mask), .num_passes(num_passes), .stall(stall),
        .sel(sel), .sel_valid(sel_valid), .first_tap(first_tap),
        .last_tap(last_tap), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected valid-cycle stream: the active tap list repeated once per pass.
    task automatic build_model(output bit legal);
        int taps[$];
        exp_sel.delete(); exp_first.delete(); exp_last.delete();
        for (int i = 0; i < 5; i++) begin
            if (i < cfg_nt) begin
`ifdef FOFIR_TAP_MASK_EN
                if (cfg_mask[i]) taps.push_back(i);
`else
                taps.push_back(i);
`endif
            end
        end
        legal = (cfg_nt >= 1) && (cfg_nt <= 5) && (cfg_np >= 1) && (taps.size() > 0);
        if (legal) begin
            for (int p = 0; p < cfg_np; p++) begin
                for (int j = 0; j < taps.size(); j++) begin
                    exp_sel.push_back(taps[j]);
                    exp_first.push_back(j == 0);
                    exp_last.push_back(j == taps.size() - 1);
                end
            end
        end
    endtask

    task automatic scramble_cfg();
        num_taps   = 3'($urandom_range(0, 7));
        tap_mask   = 5'($urandom_range(0, 31));
        num_passes = 8'($urandom_range(0, 255));
    endtask

    task automatic issue_start(input int nt, input logic [4:0] m, input int np, output bit legal);
        cfg_nt = nt; cfg_mask = m; cfg_np = np;
        build_model(legal);
        @(negedge clk);
        start = 1'b1; num_taps = 3'(nt); tap_mask = m; num_passes = 8'(np);
        stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0; stall = 1'b0;
        scramble_cfg();
    endtask

    task automatic applyStimulus(input int nt, input logic [4:0] m, input int np,
                                 input int stall_at, input int stall_len, input bit rand_stall);
        bit legal;
        int k, held, stalls;
        bit s;
        issue_start(nt, m, np, legal);
        if (!legal) begin
            checkOutput("cfg_err_pulse", cfg_err, 1);
            checkOutput("err_busy", busy, 0);
            checkOutput("err_valid", sel_valid, 0);
            @(negedge clk);
            checkOutput("cfg_err_clear", cfg_err, 0);
            checkOutput("err_busy_after", busy, 0);
            return;
        end
        checkOutput("accept_no_err", cfg_err, 0);
        k = 0; held = 0; stalls = 0;
        while (k < exp_sel.size()) begin
            checkOutput("run_valid", sel_valid, 1);
            checkOutput("run_sel", sel, exp_sel[k]);
            checkOutput("run_first", first_tap, exp_first[k]);
            checkOutput("run_last", last_tap, exp_last[k]);
            checkOutput("run_busy", busy, 1);
            checkOutput("run_done", done, 0);
            checkOutput("run_cfg_err", cfg_err, 0);
            s = 1'b0;
            if (k == stall_at && held < stall_len) begin
                s = 1'b1; held++;
            end else if (rand_stall && stalls < exp_sel.size() && $urandom_range(0, 3) == 0) begin
                s = 1'b1; stalls++;
            end
            stall = s;
            start = ($urandom_range(0, 3) == 0);
            scramble_cfg();
            @(negedge clk);
            if (!s) k++;
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("done_valid", sel_valid, 0);
        checkOutput("done_sel", sel, 0);
        checkOutput("done_busy", busy, 1);
        checkOutput("done_first", first_tap, 0);
        checkOutput("done_last", last_tap, 0);
        stall = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0; stall = 1'b0;
        checkOutput("idle_done", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_cfg_err", cfg_err, 0);
        checkOutput("idle_valid", sel_valid, 0);
    endtask

    task automatic reset_mid_run();
        bit legal;
        issue_start(5, 5'b11111, 1, legal);
        for (int k = 0; k < 3; k++) begin
            checkOutput("pre_rst_sel", sel, exp_sel[k]);
            @(negedge clk);
        end
        checkOutput("at_rst_sel", sel, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_sel", sel, 0);
        checkOutput("rst_valid", sel_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_first", first_tap, 0);
        checkOutput("rst_last", last_tap, 0);
        for (int c = 0; c < 8; c++) begin
            checkOutput("rst_no_done", done, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        num_taps = '0; tap_mask = '0; num_passes = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_sel", sel, 0);
        checkOutput("reset_valid", sel_valid, 0);
        checkOutput("reset_first", first_tap, 0);
        checkOutput("reset_last", last_tap, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        $display("[TB] directed scenarios");
        applyStimulus(5, 5'b11111, 2, -1, 0, 1'b0);
        applyStimulus(5, 5'b10101, 1, -1, 0, 1'b0);
        applyStimulus(3, 5'b11111, 1, 1, 2, 1'b0);
        applyStimulus(6, 5'b11111, 1, -1, 0, 1'b0);
        applyStimulus(5, 5'b11111, 0, -1, 0, 1'b0);
        applyStimulus(5, 5'b00000, 1, -1, 0, 1'b0);
        applyStimulus(0, 5'b11111, 1, -1, 0, 1'b0);
        applyStimulus(1, 5'b11111, 3, -1, 0, 1'b0);
        reset_mid_run();

        $display("[TB] randomized scenarios");
        for (int t = 0; t < 60; t++) begin
            int nt, np;
            logic [4:0] m;
            nt = $urandom_range(0, 6);
            m  = 5'($urandom_range(0, 31));
            np = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
            applyStimulus(nt, m, np, -1, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
